uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Asynchronous serial receiver for the 8N1 link between the system and its communication partner. It synchronizes `uart_rxd`, validates the start bit, samples each bit at mid-period, and presents the received byte through a level-valid / acknowledge handshake. It sits inside `system` between the `uart_rxd` pin and the command/LCD control logic. It is the receiving end of the same link the transmitter drives on `uart_txd`.

## Interface
- `clk_freq`, default 50000000, system clock frequency in Hz.
- `uart_baud_rate`, default 115200, line rate in bit/s. Derived constants:
  - D = clk_freq / uart_baud_rate (integer truncation), clocks per bit.
  - H = D / 2 (truncated).
  - Requirement: D ≥ 8.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `uart_rxd`  in  1  serial line; idles high.
- `rx_data`  out  8  last received byte.
- `rx_avail`  out  1  high while `rx_data` holds an unacknowledged byte.
- `rx_ack`  in  1  consumer acknowledge; single-cycle or held high.
- `rx_error`  out  1  framing error (or parity error, see Configuration) on the byte in `rx_data`.
- `rx_overrun`  out  1  a byte was overwritten before it was acknowledged.

## Operation
- **Input synchronizer:** 2-flop, reset value 1. All decisions use the synchronized bit `rxs`.
- **Bit counter:** counts 0..D-1. Bit index counter: 3 bits. Shift register: LSB first.
- **IDLE:** if `rxs` = 0, go to START and clear the counter.
- **START:** when the counter reaches H-1, sample `rxs`.
  - `rxs` = 0: go to DATA and clear the counter.
  - `rxs` = 1 (glitch): return to IDLE; no outputs change.
- **DATA:** when the counter reaches D-1, sample `rxs` into bit[index]. After bit 7, go to STOP (or PARITY when the macro is defined).
- **STOP:** when the counter reaches D-1, sample `rxs`, then on the next clock:
  - load `rx_data` with the shift register;
  - set `rx_avail` = 1;
  - set `rx_error` = (stop bit == 0), plus parity mismatch when the macro is defined;
  - if `rx_avail` was already 1 and there is no `rx_ack` this cycle, set `rx_overrun` = 1; it is sticky.
  - Then return to IDLE immediately, with no wait for line idle.
- **Framing error:** the byte is still delivered with `rx_error` = 1. The FSM returns to IDLE. If the line is still low, IDLE re-detects it as a start bit on the next cycle.
- **`rx_ack` while `rx_avail` = 1:** clears `rx_avail`, `rx_error` and `rx_overrun` on the next clock.
- **`rx_ack` while `rx_avail` = 0:** ignored.
- **Simultaneous byte completion and `rx_ack`:** the completion wins.
  - The new byte is loaded and `rx_avail` stays 1.
  - `rx_overrun` stays 0.
  - `rx_error` reflects the new frame.
- **Reset mid-frame:** the FSM goes to IDLE and the partial frame is discarded.
- **Reset values:**
  - `rx_data` = 0x00; `rx_avail`, `rx_error`, `rx_overrun` = 0;
  - all counters = 0; state = IDLE.

## Timing
- **Cycle reference:** let t0 be the first cycle in which `rxs` = 0. This is 2 clocks after the pin falls.
- **Sample points:** start bit at t0+H; data bit k (k = 0..7) at t0+H+(k+1)·D; stop bit at t0+H+9·D.
- **Output latency:** `rx_avail` rises at t0+H+9·D+1. With the parity option, add D.
- **Back-to-back frames:** supported. The FSM is in IDLE about D/2 clocks before the next start edge.
- **Handshake:** `rx_avail` falls 1 clock after the `rx_ack` sampling edge.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - The frame is 8E1: an even-parity bit follows bit 7 and is sampled at t0+H+9·D.
  - The stop bit is sampled at t0+H+10·D.
  - `rx_error` = framing error OR (XOR of data bits ≠ parity bit).
- **Not defined:** the frame is 8N1. No PARITY state exists and no parity logic is synthesized.

## Test plan
All scenarios use `clk_freq` = 50000000 and `uart_baud_rate` = 1152000, so D = 43 and H = 21. The macro is undefined unless stated.

- **Single byte:** send 0xA5 with a valid stop bit -> `rx_data` = 0xA5; `rx_avail` = 1 at t0+409; `rx_error` = 0. Pulse `rx_ack` -> `rx_avail` = 0 one clock later.
- **Glitch rejection:** drive `uart_rxd` low for 10 clocks, then high -> `rx_avail` stays 0 and the FSM returns to IDLE.
- **Framing error:** send 0x3C with stop bit = 0 -> `rx_data` = 0x3C, `rx_avail` = 1, `rx_error` = 1. A following valid 0x55 frame, after ack -> `rx_error` = 0.
- **Overrun:** send 0x11 then 0x22 back-to-back with no ack -> `rx_data` = 0x22, `rx_overrun` = 1. `rx_ack` -> `rx_overrun` = 0.
- **Ack at completion:** assert `rx_ack` in the exact load cycle of the second byte -> `rx_avail` = 1, `rx_overrun` = 0.
- **Reset and parity:**
  - Deassert-then-assert reset at bit 4 of a frame -> outputs are 0 and the next full frame 0x7E is received correctly.
  - With `UART_RX_PARITY_EN` defined, send 0x07 with parity bit 0 -> `rx_error` = 1; with parity bit 1 -> `rx_error` = 0.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling, level-valid/ack output handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking folded into rx_error.
module uart_rx_core #(
   parameter int unsigned clk_freq       = 50000000,
   parameter int unsigned uart_baud_rate = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   input  logic       rx_ack,
   output logic       rx_error,
   output logic       rx_overrun
);

   localparam int unsigned D  = clk_freq / uart_baud_rate;
   localparam int unsigned H  = D / 2;
   localparam int unsigned CW = $clog2(D);
   localparam logic [CW-1:0] D_LAST = CW'(D - 1);
   localparam logic [CW-1:0] H_LAST = CW'(H - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   logic            sync1;
   logic            rxs;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
`ifdef UART_RX_PARITY_EN
   logic            par_bit;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= uart_rxd;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         rx_data    <= '0;
         rx_avail   <= 1'b0;
         rx_error   <= 1'b0;
         rx_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         // Acknowledge clears first; a completing frame below overrides it.
         if (rx_ack && rx_avail) begin
            rx_avail   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= '0;
               end
            end

            START: begin
               if (cnt == H_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            DATA: begin
               if (cnt == D_LAST) begin
                  cnt     <= '0;
                  shift   <= {rxs, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == D_LAST) begin
                  cnt     <= '0;
                  par_bit <= rxs;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`endif

            STOP: begin
               if (cnt == D_LAST) begin
                  cnt        <= '0;
                  rx_data    <= shift;
                  rx_avail   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  rx_error   <= ~rxs | ((^shift) ^ par_bit);
`else
                  rx_error   <= ~rxs;
`endif
                  // Overrun only when the old byte is left unacknowledged; it stays sticky until acked.
                  rx_overrun <= (rx_avail & ~rx_ack) | (rx_overrun & ~(rx_avail & rx_ack));
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: driver pushes expected bytes with their due cycle, monitor checks on delivery.
// Honours UART_RX_PARITY_EN to generate 8E1 frames.
module tb_uart_rx_core;

   localparam int unsigned CLK_FREQ = 50000000;
   localparam int unsigned BAUD     = 1152000;
   localparam int unsigned D        = CLK_FREQ / BAUD;
   localparam int unsigned H        = D / 2;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned EXTRA    = 1;
`else
   localparam int unsigned EXTRA    = 0;
`endif
   // pin fall -> rxs low takes 2 clocks; stop sample at t0+H+9D (+D with parity); output one clock later
   localparam int unsigned LAT      = 2 + H + (9 + EXTRA) * D + 1;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       rx_ack   = 1'b0;
   logic [7:0] rx_data;
   logic       rx_avail;
   logic       rx_error;
   logic       rx_overrun;

   uart_rx_core #(.clk_freq(CLK_FREQ), .uart_baud_rate(BAUD)) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rxd   (uart_rxd),
      .rx_data    (rx_data),
      .rx_avail   (rx_avail),
      .rx_ack     (rx_ack),
      .rx_error   (rx_error),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  data;
      logic        err;
      logic        ovr;
      int unsigned due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   bit   pending     = 1'b0;
   bit   prev_avail  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compares each delivery against the scoreboard at its predicted cycle.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
         mon_e = sb.pop_front();
         chk("avail", 32'(rx_avail), 32'd1);
         chk("data", 32'(rx_data), 32'(mon_e.data));
         chk("error", 32'(rx_error), 32'(mon_e.err));
         chk("overrun", 32'(rx_overrun), 32'(mon_e.ovr));
      end else if (rx_avail && !prev_avail) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_avail: got rx_avail=1 data=0x%0h expected no delivery (cycle %0d)", rx_data, cyc);
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
         mon_e = sb.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missed_delivery: got nothing expected 0x%0h at cycle %0d", mon_e.data, mon_e.due);
      end
      prev_avail = rx_avail;
   end

   // Send one frame. abort_at >= 0 stops after that many data bits and pushes no expectation.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                             input bit ack_at_done, input int abort_at);
      exp_t        e;
      int unsigned f;
      logic        par;
      par = (^d) ^ ~par_ok;
      uart_rxd = 1'b0;
      f = cyc;
      if (abort_at < 0) begin
         e.data = d;
`ifdef UART_RX_PARITY_EN
         e.err  = ~stop | ~par_ok;
`else
         e.err  = ~stop;
`endif
         e.ovr  = ack_at_done ? 1'b0 : pending;
         e.due  = f + LAT;
         sb.push_back(e);
         pending = 1'b1;
         if (ack_at_done) begin
            fork
               begin
                  wait_cyc(int'(LAT) - 1);
                  rx_ack = 1'b1;
                  wait_cyc(1);
                  rx_ack = 1'b0;
               end
            join_none
         end
      end
      wait_cyc(D);
      for (int i = 0; i < 8; i++) begin
         if (abort_at == i) return;
         uart_rxd = d[i];
         wait_cyc(D);
      end
`ifdef UART_RX_PARITY_EN
      uart_rxd = par;
      wait_cyc(D);
`endif
      uart_rxd = stop;
      wait_cyc(D);
      uart_rxd = 1'b1;
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      wait_cyc(1);
      rx_ack = 1'b0;
      chk("ack_avail", 32'(rx_avail), 32'd0);
      chk("ack_error", 32'(rx_error), 32'd0);
      chk("ack_overrun", 32'(rx_overrun), 32'd0);
      pending = 1'b0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_data"}, 32'(rx_data), 32'd0);
      chk({tag, "_avail"}, 32'(rx_avail), 32'd0);
      chk({tag, "_error"}, 32'(rx_error), 32'd0);
      chk({tag, "_overrun"}, 32'(rx_overrun), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      logic       stop;
      logic       pok;
      bit         ack;

      wait_cyc(5);
      chk_cleared("reset");
      rst = 1'b1;
      wait_cyc(D);
      chk_cleared("post_reset");

      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1);
      do_ack();
      wait_cyc(D);

      uart_rxd = 1'b0;
      wait_cyc(10);
      uart_rxd = 1'b1;
      wait_cyc(2 * D);
      chk("glitch_avail", 32'(rx_avail), 32'd0);

      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
      wait_cyc(2 * D);
      do_ack();
      send_frame(8'h55, 1'b1, 1'b1, 1'b0, -1);
      do_ack();
      wait_cyc(D);

      send_frame(8'h11, 1'b1, 1'b1, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b1, 1'b0, -1);
      do_ack();
      wait_cyc(D);

      send_frame(8'h11, 1'b1, 1'b1, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b1, 1'b1, -1);
      chk("ack_at_done_avail", 32'(rx_avail), 32'd1);
      chk("ack_at_done_overrun", 32'(rx_overrun), 32'd0);
      do_ack();
      wait_cyc(D);

      send_frame(8'h99, 1'b1, 1'b1, 1'b0, -1);
      send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 4);
      rst = 1'b0;
      uart_rxd = 1'b1;
      wait_cyc(3);
      chk_cleared("mid_reset");
      rst = 1'b1;
      pending = 1'b0;
      wait_cyc(2 * D);
      chk_cleared("after_abort");
      send_frame(8'h7E, 1'b1, 1'b1, 1'b0, -1);
      do_ack();
      wait_cyc(D);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1);
      do_ack();
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
      do_ack();
      wait_cyc(D);
`endif

      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
         pok  = ($urandom_range(0, 4) != 0);
`else
         pok  = 1'b1;
`endif
         ack  = ($urandom_range(0, 1) != 0);
         send_frame(d, stop, pok, 1'b0, -1);
         if (!stop) wait_cyc(D);
         if (ack) do_ack();
         wait_cyc(int'($urandom_range(0, D)));
      end

      wait_cyc(2 * D);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule
